// File: rtl/xbar_pkg.sv
// Shared types and helpers for the stream crossbar data path.
//   xbar_lock_e : per-output lock state
//   id_width()  : bits needed to index the source streams
//   dest_width(): bits needed to index the destination streams
package xbar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } xbar_lock_e;

  // A single stream still needs a 1-bit index field.
  function automatic int id_width(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

  function automatic int dest_width(input int n_dst);
    return (n_dst > 1) ? $clog2(n_dst) : 1;
  endfunction

endpackage

// File: rtl/xbar_skid_buffer.sv
// Two-entry skid buffer with registered outputs.
// The head entry drives the output directly; the tail entry absorbs the beat
// that arrives while the head is stalled, so input ready depends on registers only.
// Ports:
//   clk_i, rst_in            clock, async active-low reset
//   in_data_i/in_valid_i     upstream beat
//   in_ready_o               upstream ready (= tail slot free)
//   out_data_o/out_valid_o   downstream beat (registered)
//   out_ready_i              downstream ready
module xbar_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_in,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic         head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
  logic         push, pop;

  // The tail is only ever occupied while the head is, so tail_vld_q means full.
  assign in_ready_o  = !tail_vld_q;
  assign out_data_o  = head_q;
  assign out_valid_o = head_vld_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = head_vld_q & out_ready_i;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (pop) begin
      if (tail_vld_q) begin
        head_d     = tail_q;
        tail_vld_d = push;
        if (push) tail_d = in_data_i;
      end else begin
        head_vld_d = push;
        if (push) head_d = in_data_i;
      end
    end else if (push) begin
      if (!head_vld_q) begin
        head_d     = in_data_i;
        head_vld_d = 1'b1;
      end else begin
        tail_d     = in_data_i;
        tail_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

endmodule

// File: rtl/stream_xbar_datapath.sv
// Packet-locked data path of the stream crossbar. Each output locks onto the
// source its arbiter grants and stays locked until that source's tlast beat
// is accepted; a skid buffer per output gives full-throughput handshaking.
//
// Lock FSM (one per output):
//   state  | meaning
//   IDLE   | no source attached; a valid grant is acked and latched
//   LOCKED | sel_q routes one source; leaves on accepted tlast beat
//
// Ports:
//   clk_i, rst_in                 clock, async active-low reset
//   s_data/dest/last/valid_i      input streams, s_ready_o back to sources
//   m_data/id/last/valid_o        output streams (registered), m_ready_i
//   grant_i, grant_valid_i        arbiter choice per output
//   grant_ack_o                   grant taken this cycle
//   release_o                     one-cycle pulse when a lock drops
module stream_xbar_datapath
  import xbar_pkg::*;
#(
  parameter  int T_DATA_WIDTH = 8,
  parameter  int S_DATA_COUNT = 2,
  parameter  int M_DATA_COUNT = 3,
  localparam int T_ID___WIDTH = id_width(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_in,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]  s_data_i,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                    s_last_i,
  input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
  output logic [S_DATA_COUNT-1:0]                    s_ready_o,
  output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_o,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  m_id_o,
  output logic [M_DATA_COUNT-1:0]                    m_last_o,
  output logic [M_DATA_COUNT-1:0]                    m_valid_o,
  input  logic [M_DATA_COUNT-1:0]                    m_ready_i,
  input  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  grant_i,
  input  logic [M_DATA_COUNT-1:0]                    grant_valid_i,
  output logic [M_DATA_COUNT-1:0]                    grant_ack_o,
  output logic [M_DATA_COUNT-1:0]                    release_o
);

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_ID___WIDTH-1:0] id;
    logic                    last;
  } skid_entry_t;

  localparam int ENTRY_W = $bits(skid_entry_t);

  xbar_lock_e              lock_q [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] sel_q  [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] release_q;

  logic [M_DATA_COUNT-1:0] conn, skid_in_valid, skid_in_ready, accept;
  skid_entry_t             skid_in  [M_DATA_COUNT];
  skid_entry_t             skid_out [M_DATA_COUNT];

  assign release_o = release_q;

  // A locked source only connects while its current beat targets this output,
  // so at most one output can claim a given source's ready in any cycle.
  always_comb begin
    s_ready_o     = '0;
    conn          = '0;
    skid_in_valid = '0;
    accept        = '0;
    grant_ack_o   = '0;
    for (int j = 0; j < M_DATA_COUNT; j++) begin
      skid_in[j].data  = s_data_i[sel_q[j]];
      skid_in[j].id    = sel_q[j];
      skid_in[j].last  = s_last_i[sel_q[j]];
      conn[j]          = (lock_q[j] == LOCKED) &&
                         (s_dest_i[sel_q[j]] == T_DEST_WIDTH'(j));
      skid_in_valid[j] = conn[j] & s_valid_i[sel_q[j]];
      accept[j]        = skid_in_valid[j] & skid_in_ready[j];
      // Gated by rst_in so the ack reads 0 while reset is held.
      grant_ack_o[j]   = rst_in & (lock_q[j] == IDLE) & grant_valid_i[j];
      for (int i = 0; i < S_DATA_COUNT; i++) begin
        if (conn[j] && (sel_q[j] == T_ID___WIDTH'(i))) s_ready_o[i] = skid_in_ready[j];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      release_q <= '0;
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        lock_q[j] <= IDLE;
        sel_q[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        release_q[j] <= 1'b0;
        case (lock_q[j])
          IDLE: begin
            if (grant_valid_i[j]) begin
              sel_q[j]  <= grant_i[j];
              lock_q[j] <= LOCKED;
            end
          end
          LOCKED: begin
            if (accept[j] && s_last_i[sel_q[j]]) begin
              lock_q[j]    <= IDLE;
              release_q[j] <= 1'b1;
            end
          end
          default: lock_q[j] <= IDLE;
        endcase
      end
    end
  end

  for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_out
    xbar_skid_buffer #(
      .W (ENTRY_W)
    ) u_skid (
      .clk_i       (clk_i),
      .rst_in      (rst_in),
      .in_data_i   (skid_in[j]),
      .in_valid_i  (skid_in_valid[j]),
      .in_ready_o  (skid_in_ready[j]),
      .out_data_o  (skid_out[j]),
      .out_valid_o (m_valid_o[j]),
      .out_ready_i (m_ready_i[j])
    );
    assign m_data_o[j] = skid_out[j].data;
    assign m_id_o[j]   = skid_out[j].id;
    assign m_last_o[j] = skid_out[j].last;
  end

endmodule

// File: tb/tb_stream_xbar_datapath.sv
module tb_stream_xbar_datapath;
  localparam int DW = 8, S = 2, M = 3, IW = 1, DSTW = 2;

  logic                     clk_i = 1'b0;
  logic                     rst_in;
  logic [S-1:0][DW-1:0]     s_data_i;
  logic [S-1:0][DSTW-1:0]   s_dest_i;
  logic [S-1:0]             s_last_i, s_valid_i, s_ready_o;
  logic [M-1:0][DW-1:0]     m_data_o;
  logic [M-1:0][IW-1:0]     m_id_o, grant_i;
  logic [M-1:0]             m_last_o, m_valid_o, m_ready_i;
  logic [M-1:0]             grant_valid_i, grant_ack_o, release_o;

  always #5 clk_i = ~clk_i;

  stream_xbar_datapath dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .s_data_i(s_data_i), .s_dest_i(s_dest_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_id_o(m_id_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .grant_i(grant_i), .grant_valid_i(grant_valid_i),
    .grant_ack_o(grant_ack_o), .release_o(release_o)
  );

  typedef struct {
    logic [DW-1:0]   data;
    logic [DSTW-1:0] dest;
    logic            last;
  } beat_t;

  // Reference model: pending beats per source, expected {data,id,last} per output.
  beat_t       src_q [S][$];
  logic [9:0]  exp_q [M][$];
  int          n_assert = 0, n_fail = 0;
  int          rel_cnt [M];
  logic [S-1:0] fire_s, sr_s;
  logic [M-1:0] fire_m, ack_s, rel_s, mv_s, hold_q;
  logic [9:0]  hold_b [M];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < S; i++) if (src_q[i].size() > 0) p = 1'b1;
    for (int j = 0; j < M; j++) if (exp_q[j].size() > 0) p = 1'b1;
    return p;
  endfunction

  function automatic logic [63:0] all_outputs();
    return {23'd0, m_valid_o, m_last_o, m_data_o, m_id_o, s_ready_o, grant_ack_o, release_o};
  endfunction

  // One clock: drive sources from their queues, observe and score at negedge.
  task automatic step();
    logic [9:0] e, got;
    for (int i = 0; i < S; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid_i[i] = 1'b1;
        s_data_i[i]  = src_q[i][0].data;
        s_dest_i[i]  = src_q[i][0].dest;
        s_last_i[i]  = src_q[i][0].last;
      end else begin
        s_valid_i[i] = 1'b0;
        s_data_i[i]  = DW'($urandom);
        s_dest_i[i]  = DSTW'($urandom);
        s_last_i[i]  = 1'($urandom);
      end
    end
    @(negedge clk_i);
    fire_s = s_valid_i & s_ready_o;
    fire_m = m_valid_o & m_ready_i;
    ack_s  = grant_ack_o;
    rel_s  = release_o;
    mv_s   = m_valid_o;
    sr_s   = s_ready_o;
    for (int j = 0; j < M; j++) begin
      got = {m_data_o[j], m_id_o[j], m_last_o[j]};
      if (hold_q[j]) check($sformatf("hold_stable_out%0d", j), got, hold_b[j]);
      if (rel_s[j]) rel_cnt[j]++;
      if (fire_m[j]) begin
        check($sformatf("beat_expected_out%0d", j), exp_q[j].size() > 0, 1);
        if (exp_q[j].size() > 0) begin
          e = exp_q[j].pop_front();
          check($sformatf("beat_out%0d", j), got, e);
        end
      end
      hold_q[j] = m_valid_o[j] & !m_ready_i[j];
      hold_b[j] = got;
    end
    @(posedge clk_i);
    #1;
    for (int i = 0; i < S; i++) if (fire_s[i]) void'(src_q[i].pop_front());
  endtask

  task automatic push_pkt(input int src, input int dst, input int len, input bit expect_it);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DW'($urandom);
      b.dest = DSTW'(dst);
      b.last = (k == len - 1);
      src_q[src].push_back(b);
      if (expect_it) exp_q[dst].push_back({b.data, IW'(src), b.last});
    end
  endtask

  task automatic grant(input int j, input int src);
    grant_i[j]       = IW'(src);
    grant_valid_i[j] = 1'b1;
    step();
    check($sformatf("grant_ack_out%0d", j), ack_s[j], 1);
    grant_valid_i[j] = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      m_ready_i = rnd ? M'($urandom) : '1;
      step();
      n++;
    end
    check("drain_complete", pending(), 0);
  endtask

  initial begin
    int fa, rel_k, rk0, rk2, r0, r2, occ, ack_k, last_k, ja, jb;
    bit p, p0, p1, saw_full;
    logic [15:0] mv_mask, fire_mask;
    int rel_exp [M];
    logic pat [4];

    rst_in = 1'b0; s_data_i = '0; s_dest_i = '0; s_last_i = '0; s_valid_i = '0;
    m_ready_i = '0; grant_i = '0; grant_valid_i = '0; hold_q = '0;
    for (int j = 0; j < M; j++) rel_cnt[j] = 0;

    // 1. reset with random inputs, then async assertion mid-cycle
    for (int k = 0; k < 5; k++) begin
      s_data_i = (S*DW)'($urandom); s_dest_i = (S*DSTW)'($urandom);
      s_last_i = S'($urandom); s_valid_i = S'($urandom); m_ready_i = M'($urandom);
      grant_i = (M*IW)'($urandom); grant_valid_i = M'($urandom);
      @(negedge clk_i);
      check("reset_outputs", all_outputs(), 0);
      @(posedge clk_i); #1;
    end
    s_valid_i = '0; grant_valid_i = '0; grant_i = '0; m_ready_i = '0;
    rst_in = 1'b1;
    grant(1, 0);
    push_pkt(0, 1, 1, 1);
    step();
    step();
    check("t1_valid_before_reset", mv_s[1], 1);
    #2 rst_in = 1'b0;
    #1 check("async_reset_clear", all_outputs(), 0);
    for (int i = 0; i < S; i++) src_q[i].delete();
    for (int j = 0; j < M; j++) exp_q[j].delete();
    hold_q = '0;
    #1 rst_in = 1'b1;
    @(posedge clk_i); #1;

    // 2. basic 4-beat packet src0 -> out1, nothing passes in the ack cycle
    m_ready_i = '1;
    push_pkt(0, 1, 4, 1);
    grant(1, 0);
    check("t2_no_pass_in_ack", sr_s[0], 0);
    fa = -1; rel_k = -1; mv_mask = '0; fire_mask = '0; r2 = rel_cnt[1];
    for (int k = 0; k < 10; k++) begin
      step();
      if (fire_s[0] && fa < 0) fa = k;
      if (fire_s[0]) fire_mask[k] = 1'b1;
      if (mv_s[1]) mv_mask[k] = 1'b1;
      if (rel_s[1]) rel_k = k;
    end
    check("t2_first_accept", fa, 0);
    check("t2_accept_run", fire_mask, 16'h000f);
    check("t2_valid_window", mv_mask, 16'h001e);
    check("t2_release_count", rel_cnt[1] - r2, 1);
    check("t2_release_cycle", rel_k, 4);
    check("t2_drained", pending(), 0);

    // 3. backpressure 1,0,0,1 on out1 with a 6-beat packet
    grant(1, 0);
    push_pkt(0, 1, 6, 1);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    occ = 0; saw_full = 1'b0;
    for (int k = 0; k < 60 && pending(); k++) begin
      m_ready_i = 3'b111;
      m_ready_i[1] = pat[k % 4];
      p = src_q[0].size() > 0;
      step();
      if (p) check("t3_ready_vs_full", sr_s[0], occ < 2);
      if (occ == 2) saw_full = 1'b1;
      occ = occ + int'(fire_s[0]) - int'(fire_m[1]);
    end
    check("t3_saw_full", saw_full, 1);
    check("t3_drained", pending(), 0);

    // 4. dest mismatch: src1 locked to out0 but beats target out2
    m_ready_i = '1;
    grant(0, 1);
    push_pkt(1, 2, 3, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_src1_ready", sr_s[1], 0);
      check("t4_out0_valid", mv_s[0], 0);
    end
    for (int k = 0; k < src_q[1].size(); k++) begin
      src_q[1][k].dest = 2'd0;
      exp_q[0].push_back({src_q[1][k].data, 1'b1, src_q[1][k].last});
    end
    drain(1'b0, 50);

    // 5. parallel: src0 -> out2 and src1 -> out0
    grant_i[2] = 1'b0; grant_valid_i[2] = 1'b1;
    grant_i[0] = 1'b1; grant_valid_i[0] = 1'b1;
    step();
    check("t5_ack_out2", ack_s[2], 1);
    check("t5_ack_out0", ack_s[0], 1);
    grant_valid_i = '0;
    push_pkt(0, 2, 5, 1);
    push_pkt(1, 0, 7, 1);
    m_ready_i = '1;
    r0 = rel_cnt[0]; r2 = rel_cnt[2]; rk0 = -1; rk2 = -1;
    for (int k = 0; k < 12; k++) begin
      p0 = src_q[0].size() > 0;
      p1 = src_q[1].size() > 0;
      step();
      if (p0) check("t5_src0_rate", fire_s[0], 1);
      if (p1) check("t5_src1_rate", fire_s[1], 1);
      if (rel_s[2]) rk2 = k;
      if (rel_s[0]) rk0 = k;
    end
    check("t5_rel_count_out2", rel_cnt[2] - r2, 1);
    check("t5_rel_count_out0", rel_cnt[0] - r0, 1);
    check("t5_rel_cycle_out2", rk2, 5);
    check("t5_rel_cycle_out0", rk0, 7);
    drain(1'b0, 20);

    // 6. re-grant presented while locked
    grant(1, 0);
    grant_i[1] = 1'b1; grant_valid_i[1] = 1'b1;
    push_pkt(0, 1, 3, 1);
    ack_k = -1; last_k = -1;
    for (int k = 0; k < 10 && ack_k < 0; k++) begin
      p = src_q[0].size() == 1;
      step();
      if (fire_s[0] && p) last_k = k;
      if (ack_s[1]) begin
        ack_k = k;
        check("t6_release_with_ack", rel_s[1], 1);
      end
    end
    grant_valid_i[1] = 1'b0;
    check("t6_last_cycle", last_k, 2);
    check("t6_ack_cycle", ack_k, last_k + 1);
    push_pkt(1, 1, 2, 1);
    drain(1'b0, 30);

    // random phase: two concurrent packets to distinct outputs, random m_ready
    for (int j = 0; j < M; j++) rel_exp[j] = rel_cnt[j];
    for (int it = 0; it < 12; it++) begin
      ja = $urandom_range(0, M - 1);
      jb = (ja + 1 + $urandom_range(0, 1)) % M;
      grant_i[ja] = 1'b0; grant_valid_i[ja] = 1'b1;
      grant_i[jb] = 1'b1; grant_valid_i[jb] = 1'b1;
      step();
      check("rnd_ack_a", ack_s[ja], 1);
      check("rnd_ack_b", ack_s[jb], 1);
      grant_valid_i = '0;
      push_pkt(0, ja, $urandom_range(1, 6), 1);
      push_pkt(1, jb, $urandom_range(1, 6), 1);
      rel_exp[ja]++;
      rel_exp[jb]++;
      drain(1'b1, 400);
    end
    for (int j = 0; j < M; j++) check($sformatf("rnd_release_out%0d", j), rel_cnt[j], rel_exp[j]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
